// File: rtl/full_adder_unit.sv
// Width-parameterizable ripple-carry full adder built from 1-bit cells,
// with an optional single-cycle output register stage.
module full_adder_unit #(
    parameter int WIDTH   = 1,
    parameter int OUT_REG = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             out_valid
);

    // One full-adder cell: returns {carry_out, sum}.
    function automatic logic [1:0] fa_cell(input logic ai, input logic bi, input logic ci);
        logic v_p;
        v_p     = ai ^ bi;
        fa_cell = {(ai & bi) | (ci & v_p), v_p ^ ci};
    endfunction

    logic [WIDTH-1:0] w_sum;
    logic             w_cout;

    // Ripple the carry through every cell within one cycle.
    always_comb begin : p_chain
        logic       v_carry;
        logic [1:0] v_cell;
        w_sum   = {WIDTH{1'b0}};
        v_carry = cin;
        v_cell  = 2'b00;
        for (int i = 0; i < WIDTH; i++) begin
            v_cell   = fa_cell(a[i], b[i], v_carry);
            w_sum[i] = v_cell[0];
            v_carry  = v_cell[1];
        end
        w_cout = v_carry;
    end

    generate
        if (OUT_REG != 0) begin : g_reg
            logic [WIDTH-1:0] r_s;
            logic             r_cout;
            logic             r_valid;

            // Result register: reset wins over in_valid; idle cycles keep the last result.
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_s     <= {WIDTH{1'b0}};
                    r_cout  <= 1'b0;
                    r_valid <= 1'b0;
                end else if (in_valid) begin
                    r_s     <= w_sum;
                    r_cout  <= w_cout;
                    r_valid <= 1'b1;
                end else begin
                    r_valid <= 1'b0;
                end
            end

            assign s         = r_s;
            assign cout      = r_cout;
            assign out_valid = r_valid;
        end else begin : g_comb
            // Datapath is purely combinational; only the valid flag sees rst.
            assign s         = w_sum;
            assign cout      = w_cout;
            assign out_valid = in_valid & ~rst;
        end
    endgenerate

endmodule

// File: tb/tb_full_adder_unit.sv
// Directed self-checking bench: 1-bit and 8-bit registered adders plus a
// 4-bit combinational adder, all against hand-computed results.
module tb_full_adder_unit;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;

    logic [0:0] a1 = 1'b0, b1 = 1'b0;
    logic       cin1 = 1'b0;
    logic [0:0] s1;
    logic       cout1, ov1;

    logic [7:0] a8 = 8'h00, b8 = 8'h00;
    logic       cin8 = 1'b0;
    logic [7:0] s8;
    logic       cout8, ov8;

    logic [3:0] a4 = 4'h0, b4 = 4'h0;
    logic       cin4 = 1'b0;
    logic [3:0] s4;
    logic       cout4, ov4;

    int total = 0;
    int bad   = 0;

    logic [7:0] exp_s_tbl    = 8'b1001_0110;
    logic [7:0] exp_cout_tbl = 8'b1110_1000;

    always #5 clk = ~clk;

    full_adder_unit #(.WIDTH(1), .OUT_REG(1)) u_w1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .a(a1), .b(b1), .cin(cin1),
        .s(s1), .cout(cout1), .out_valid(ov1)
    );

    full_adder_unit #(.WIDTH(8), .OUT_REG(1)) u_w8 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .a(a8), .b(b8), .cin(cin8),
        .s(s8), .cout(cout8), .out_valid(ov8)
    );

    full_adder_unit #(.WIDTH(4), .OUT_REG(0)) u_w4 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .a(a4), .b(b4), .cin(cin4),
        .s(s4), .cout(cout4), .out_valid(ov4)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check8(input string tag, input logic [7:0] es, input logic ec, input logic ev);
        check_eq({tag, ".s"},    64'(s8),    64'(es));
        check_eq({tag, ".cout"}, 64'(cout8), 64'(ec));
        check_eq({tag, ".ov"},   64'(ov8),   64'(ev));
    endtask

    initial begin
        // Reset for two cycles.
        rst = 1'b1;
        in_valid = 1'b0;
        step();
        step();
        check_eq("rst.w1.s",    64'(s1),    64'd0);
        check_eq("rst.w1.cout", 64'(cout1), 64'd0);
        check_eq("rst.w1.ov",   64'(ov1),   64'd0);
        check8("rst.w8", 8'h00, 1'b0, 1'b0);

        // Exhaustive 1-bit truth table, back to back.
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            logic [2:0] v_k;
            v_k      = 3'(k);
            a1       = v_k[2];
            b1       = v_k[1];
            cin1     = v_k[0];
            in_valid = 1'b1;
            step();
            check_eq($sformatf("tt%0d.s", k),    64'(s1),    64'(exp_s_tbl[k]));
            check_eq($sformatf("tt%0d.cout", k), 64'(cout1), 64'(exp_cout_tbl[k]));
            check_eq($sformatf("tt%0d.ov", k),   64'(ov1),   64'd1);
        end

        // 8-bit carry chain cases.
        a8 = 8'hFF; b8 = 8'h00; cin8 = 1'b1;
        step();
        check8("ff+00+1", 8'h00, 1'b1, 1'b1);
        a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
        step();
        check8("ff+ff+1", 8'hFF, 1'b1, 1'b1);
        a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0;
        step();
        check8("00+00+0", 8'h00, 1'b0, 1'b1);
        a8 = 8'hA5; b8 = 8'h5A; cin8 = 1'b1;
        step();
        check8("a5+5a+1", 8'h00, 1'b1, 1'b1);
        a8 = 8'h3C; b8 = 8'h0F; cin8 = 1'b1;
        step();
        check8("3c+0f+1", 8'h4C, 1'b0, 1'b1);

        // Hold: result persists while in_valid is low.
        a8 = 8'h12; b8 = 8'h34; cin8 = 1'b0;
        step();
        check8("12+34", 8'h46, 1'b0, 1'b1);
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            a8 = 8'(8'hF0 + k);
            b8 = 8'(8'h0F * (k + 1));
            cin8 = 1'b1;
            step();
            check8($sformatf("hold%0d", k), 8'h46, 1'b0, 1'b0);
        end

        // Reset collides with a valid input; the input must vanish.
        rst = 1'b1; in_valid = 1'b1;
        a8 = 8'h80; b8 = 8'h80; cin8 = 1'b0;
        step();
        check8("rstcol", 8'h00, 1'b0, 1'b0);
        rst = 1'b0; in_valid = 1'b0;
        step();
        check8("rstcol.after", 8'h00, 1'b0, 1'b0);

        // Combinational variant responds without a clock edge.
        in_valid = 1'b1;
        a4 = 4'h9; b4 = 4'h7; cin4 = 1'b0;
        #2;
        check_eq("c4.9+7.s",    64'(s4),    64'h0);
        check_eq("c4.9+7.cout", 64'(cout4), 64'd1);
        check_eq("c4.ov",       64'(ov4),   64'd1);
        rst = 1'b1;
        a4 = 4'h5; b4 = 4'h2; cin4 = 1'b0;
        #2;
        check_eq("c4.rst.ov",   64'(ov4),   64'd0);
        check_eq("c4.5+2.s",    64'(s4),    64'h7);
        check_eq("c4.5+2.cout", 64'(cout4), 64'd0);
        a4 = 4'hF; b4 = 4'hF; cin4 = 1'b1;
        #2;
        check_eq("c4.f+f+1.s",    64'(s4),    64'hF);
        check_eq("c4.f+f+1.cout", 64'(cout4), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
